// File: rtl/dp_seq_pkg.sv
// Shared encodings for the dp_ctrl_seq instruction sequencer: instruction
// classes, FSM states, instruction field positions and the zero register.
package dp_seq_pkg;

  typedef enum logic [1:0] {
    CLS_R    = 2'b00,
    CLS_I    = 2'b01,
    CLS_LOAD = 2'b10,
    CLS_HALT = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC    = 3'd1,
    WAIT_LD = 3'd2,
    WB      = 3'd3,
    HALT    = 3'd4
  } state_e;

  localparam int CLS_HI = 31;
  localparam int CLS_LO = 30;
  localparam int FS_HI  = 29;
  localparam int FS_LO  = 25;
  localparam int RR_HI  = 24;
  localparam int RR_LO  = 20;
  localparam int RA_HI  = 19;
  localparam int RA_LO  = 15;
  localparam int RB_HI  = 14;
  localparam int RB_LO  = 10;
  localparam int C0_BIT = 9;
  localparam int IMM_HI = 14;
  localparam int IMM_LO = 0;

  localparam logic [4:0] ZERO_REG = 5'd31;

endpackage

// File: rtl/dp_seq_decode.sv
// Combinational instruction decoder: splits a 32-bit word into class, register
// addresses and the control values driven onto the datapath.
module dp_seq_decode
  import dp_seq_pkg::*;
(
  input  logic [31:0] instr,
  output cls_e        cls,
  output logic [4:0]  fs,
  output logic [4:0]  addrR,
  output logic [4:0]  addrA,
  output logic [4:0]  addrB,
  output logic [63:0] k,
  output logic        s,
  output logic        c0
);

  always_comb begin
    cls   = cls_e'(instr[CLS_HI:CLS_LO]);
    fs    = instr[FS_HI:FS_LO];
    addrR = instr[RR_HI:RR_LO];
    addrA = instr[RA_HI:RA_LO];
    addrB = '0;
    k     = '0;
    s     = 1'b0;
    c0    = 1'b0;
    case (cls)
      CLS_R: begin
        addrB = instr[RB_HI:RB_LO];
        c0    = instr[C0_BIT];
      end
      // Immediate replaces the B operand; B address is parked at 0.
      CLS_I: begin
        k = 64'(instr[IMM_HI:IMM_LO]);
        s = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dp_ctrl_seq.sv
// Instruction sequencer driving the alu_reg datapath controls.
// Optional flag register enabled by defining DP_SEQ_FLAGS_EN.
module dp_ctrl_seq
  import dp_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [63:0]      ld_data,
  input  logic             ld_valid,
  input  logic [63:0]      f,
  input  logic [3:0]       status,
  output logic [4:0]       fs,
  output logic [4:0]       addrR,
  output logic [4:0]       addrA,
  output logic [4:0]       addrB,
  output logic [63:0]      k,
  output logic             s,
  output logic             sb,
  output logic             sd,
  output logic             c0,
  output logic             w,
  output logic [63:0]      din,
  output logic             busy,
  output logic             halted,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] retired
);

  state_e      state, state_nxt;
  cls_e        cls_q;
  cls_e        dec_cls;
  logic [4:0]  dec_fs, dec_addrR, dec_addrA, dec_addrB;
  logic [63:0] dec_k;
  logic        dec_s, dec_c0;
  logic        accept;

  dp_seq_decode u_decode (
    .instr (instr),
    .cls   (dec_cls),
    .fs    (dec_fs),
    .addrR (dec_addrR),
    .addrA (dec_addrA),
    .addrB (dec_addrB),
    .k     (dec_k),
    .s     (dec_s),
    .c0    (dec_c0)
  );

  assign accept = (state == IDLE) && instr_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = (dec_cls == CLS_HALT) ? HALT : EXEC;
      EXEC:    state_nxt = (cls_q == CLS_LOAD) ? WAIT_LD : WB;
      WAIT_LD: if (ld_valid) state_nxt = WB;
      WB:      state_nxt = IDLE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Decode -> control registers; held between instructions until next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cls_q   <= CLS_R;
      fs      <= '0;
      addrR   <= '0;
      addrA   <= '0;
      addrB   <= '0;
      k       <= '0;
      s       <= 1'b0;
      c0      <= 1'b0;
      din     <= '0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cls_q <= dec_cls;
        fs    <= dec_fs;
        addrR <= dec_addrR;
        addrA <= dec_addrA;
        addrB <= dec_addrB;
        k     <= dec_k;
        s     <= dec_s;
        c0    <= dec_c0;
      end
      if (state == EXEC && cls_q != CLS_LOAD) din <= f;
      if (state == WAIT_LD && ld_valid)       din <= ld_data;
      if (state == WB)                        retired <= retired + CNT_W'(1);
    end
  end

  // Reset in WB must still swallow the write strobe.
  assign w           = (state == WB) && (addrR != ZERO_REG) && !rst;
  assign instr_ready = (state == IDLE);
  assign busy        = (state == EXEC) || (state == WAIT_LD) || (state == WB);
  assign halted      = (state == HALT);
  assign sb          = 1'b1;
  assign sd          = 1'b1;

`ifdef DP_SEQ_FLAGS_EN
  logic [3:0] flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (state == WB && (cls_q == CLS_R || cls_q == CLS_I)) begin
      flags_q <= status;
    end
  end

  assign flags = flags_q;
`else
  logic unused_status;

  assign unused_status = ^status;
  assign flags         = '0;
`endif

endmodule

// File: tb/tb_dp_ctrl_seq.sv
// Bench for dp_ctrl_seq: directed scenarios plus randomized instruction
// streams checked against a transaction-level model of the sequencer.
module tb_dp_ctrl_seq;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [63:0]      ld_data;
  logic             ld_valid;
  logic [63:0]      f;
  logic [3:0]       status;
  logic [4:0]       fs, addrR, addrA, addrB;
  logic [63:0]      k;
  logic             s, sb, sd, c0, w;
  logic [63:0]      din;
  logic             busy, halted;
  logic [3:0]       flags;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  dp_ctrl_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ld_data(ld_data), .ld_valid(ld_valid),
    .f(f), .status(status), .fs(fs), .addrR(addrR), .addrA(addrA),
    .addrB(addrB), .k(k), .s(s), .sb(sb), .sd(sd), .c0(c0), .w(w),
    .din(din), .busy(busy), .halted(halted), .flags(flags),
    .retired(retired)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          cls;
    logic [4:0]  fs, rr, ra, rb;
    logic [63:0] k;
    logic        s, c0;
  } fld_t;

  logic [63:0]      regs [32];
  logic [CNT_W-1:0] ret_m;
  logic [3:0]       flags_m;

  function automatic fld_t model(input logic [31:0] ins);
    fld_t d;
    d.cls = int'(ins >> 30);
    d.fs  = 5'((ins >> 25) & 32'h1f);
    d.rr  = 5'((ins >> 20) & 32'h1f);
    d.ra  = 5'((ins >> 15) & 32'h1f);
    d.rb  = 5'd0;
    d.k   = 64'd0;
    d.s   = 1'b0;
    d.c0  = 1'b0;
    if (d.cls == 0) begin
      d.rb = 5'((ins >> 10) & 32'h1f);
      d.c0 = 1'((ins >> 9) & 32'h1);
    end else if (d.cls == 1) begin
      d.k = 64'(ins & 32'h7fff);
      d.s = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] f5, input logic [4:0] rr,
                                       input logic [4:0] ra, input logic [4:0] rb, input logic cin);
    return {2'b00, f5, rr, ra, rb, cin, 9'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] f5, input logic [4:0] rr,
                                       input logic [4:0] ra, input logic [14:0] imm);
    return {2'b01, f5, rr, ra, imm};
  endfunction

  function automatic logic [31:0] mk_ld(input logic [4:0] rr);
    return {2'b10, 5'd0, rr, 5'd0, 15'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string t);
    chk({t, "_fs"}, fs, 0);
    chk({t, "_addrR"}, addrR, 0);
    chk({t, "_addrA"}, addrA, 0);
    chk({t, "_addrB"}, addrB, 0);
    chk({t, "_k"}, k, 0);
    chk({t, "_s"}, s, 0);
    chk({t, "_c0"}, c0, 0);
    chk({t, "_sb"}, sb, 1);
    chk({t, "_sd"}, sd, 1);
    chk({t, "_w"}, w, 0);
    chk({t, "_din"}, din, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_halted"}, halted, 0);
    chk({t, "_ready"}, instr_ready, 1);
    chk({t, "_flags"}, flags, 0);
    chk({t, "_retired"}, retired, 0);
  endtask

  // One instruction from accept to return-to-idle, checked cycle by cycle.
  task automatic run(input logic [31:0] ins, input int dly, input logic [63:0] ldv,
                     input logic [3:0] st, input bit hold, input logic [31:0] nxt);
    fld_t        d;
    logic [63:0] fexp, opb;
    d = model(ins);
    instr       = ins;
    instr_valid = 1'b1;
    ld_valid    = 1'b0;
    chk("accept_ready", instr_ready, 1);
    tick();
    if (hold) instr = nxt;
    else begin
      instr_valid = 1'b0;
      instr       = $urandom;
    end
    if (d.cls == 3) begin
      chk("halt_halted", halted, 1);
      chk("halt_ready", instr_ready, 0);
      chk("halt_busy", busy, 0);
      return;
    end
    chk("exec_busy", busy, 1);
    chk("exec_ready", instr_ready, 0);
    chk("exec_w", w, 0);
    chk("exec_fs", fs, d.fs);
    chk("exec_addrR", addrR, d.rr);
    chk("exec_addrA", addrA, d.ra);
    if (d.cls < 2) begin
      chk("exec_addrB", addrB, d.rb);
      chk("exec_k", k, d.k);
      chk("exec_s", s, d.s);
      chk("exec_c0", c0, d.c0);
    end
    if (d.fs == 5'd12) begin
      opb  = d.s ? d.k : regs[d.rb];
      fexp = regs[d.ra] + opb;
    end else begin
      fexp = {$urandom, $urandom};
    end
    f        = fexp;
    ld_valid = 1'($urandom_range(0, 1));
    ld_data  = {$urandom, $urandom};
    tick();
    f = {$urandom, $urandom};
    if (d.cls == 2) begin
      for (int i = 0; i < dly; i++) begin
        ld_valid = 1'b0;
        ld_data  = {$urandom, $urandom};
        chk("wait_busy", busy, 1);
        chk("wait_w", w, 0);
        tick();
      end
      ld_valid = 1'b1;
      ld_data  = ldv;
      chk("wait_w", w, 0);
      chk("wait_busy", busy, 1);
      tick();
      fexp = ldv;
    end
    ld_valid = 1'b0;
    status   = st;
    chk("wb_w", w, (d.rr != 5'd31));
    chk("wb_din", din, fexp);
    chk("wb_busy", busy, 1);
    chk("wb_addrR", addrR, d.rr);
    if (d.rr != 5'd31) regs[d.rr] = fexp;
    ret_m++;
`ifdef DP_SEQ_FLAGS_EN
    if (d.cls < 2) flags_m = st;
`endif
    tick();
    status = 4'($urandom);
    chk("idle_w", w, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", instr_ready, 1);
    chk("idle_retired", retired, ret_m);
    chk("idle_flags", flags, flags_m);
    chk("idle_fs_held", fs, d.fs);
    chk("idle_din_held", din, fexp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] cur, nx, r;
    logic [1:0]  c;
    bit          hold;
    for (int i = 0; i < 32; i++) regs[i] = 64'd0;
    ret_m       = '0;
    flags_m     = '0;
    rst         = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    ld_data     = '0;
    ld_valid    = 1'b0;
    f           = '0;
    status      = '0;
    tick();
    tick();
    rst = 1'b0;
    check_reset("rst0");

    // Reset while in EXEC aborts the instruction.
    instr       = mk_r(5'd12, 5'd3, 5'd1, 5'd2, 1'b0);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    rst         = 1'b1;
    chk("abort_exec_busy", busy, 1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_w", w, 0);
      chk("abort_retired", retired, 0);
      chk("abort_busy", busy, 0);
      tick();
    end

    run(mk_ld(5'd23), 0, 64'd5, 4'h1, 1'b0, 32'd0);
    run(mk_ld(5'd20), 2, 64'd18, 4'h2, 1'b0, 32'd0);
    run(mk_r(5'b01100, 5'd0, 5'd23, 5'd20, 1'b0), 0, 64'd0, 4'h5, 1'b0, 32'd0);
    chk("add_result_r0", regs[0], 64'd23);
    chk("retired_after_add", retired, 3);

    run(mk_ld(5'd21), 1, 64'd7, 4'h0, 1'b0, 32'd0);
    run(mk_i(5'b10000, 5'd1, 5'd21, 15'd3), 0, 64'd0, 4'ha, 1'b0, 32'd0);
    run(mk_ld(5'd5), 5, 64'hDEAD_BEEF, 4'h3, 1'b0, 32'd0);
    run(mk_r(5'd12, 5'd31, 5'd5, 5'd23, 1'b1), 0, 64'd0, 4'hc, 1'b0, 32'd0);

    // Back-to-back: next word held valid while the current one executes.
    run(mk_r(5'd12, 5'd7, 5'd5, 5'd0, 1'b1), 0, 64'd0, 4'h6, 1'b1,
        mk_i(5'd12, 5'd8, 5'd7, 15'h7fff));
    run(mk_i(5'd12, 5'd8, 5'd7, 15'h7fff), 0, 64'd0, 4'h9, 1'b0, 32'd0);

    cur = mk_r(5'd12, 5'd9, 5'd8, 5'd7, 1'b0);
    for (int n = 0; n < 40; n++) begin
      r  = $urandom;
      c  = 2'($urandom_range(0, 2));
      nx = {c, r[29:0]};
      hold = ($urandom_range(0, 3) == 0);
      run(cur, $urandom_range(0, 3), {$urandom, $urandom}, 4'($urandom), hold, nx);
      cur = nx;
    end

    run({2'b11, 30'd0}, 0, 64'd0, 4'h0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      instr       = mk_r(5'd12, 5'd2, 5'd3, 5'd4, 1'b0);
      instr_valid = 1'b1;
      ld_valid    = 1'b1;
      tick();
      chk("halt_stay", halted, 1);
      chk("halt_ready_low", instr_ready, 0);
      chk("halt_no_w", w, 0);
      chk("halt_not_busy", busy, 0);
    end
    instr_valid = 1'b0;
    ld_valid    = 1'b0;
    rst         = 1'b1;
    tick();
    rst     = 1'b0;
    ret_m   = '0;
    flags_m = '0;
    check_reset("rst_halt");
    run(mk_r(5'd12, 5'd4, 5'd5, 5'd21, 1'b0), 0, 64'd0, 4'hf, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dp_ctrl_seq.md
# dp_ctrl_seq

Instruction sequencer that drives the control inputs of the `alu_reg` datapath: register addresses, ALU function select, immediate, write enable and write data. It accepts 32-bit instruction words over a valid/ready handshake and steps each one through a fixed decode/execute/write-back sequence. It replaces the hand-timed control stimulus used in datapath-level benches and sits between the instruction source and `alu_reg`.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all logic rises on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `instr`  in  32  instruction word.
- `instr_valid`  in  1  `instr` is valid.
- `instr_ready`  out  1  sequencer accepts `instr`.
- `ld_data`  in  64  external load data.
- `ld_valid`  in  1  `ld_data` is valid.
- `f`  in  64  ALU result from the datapath.
- `status`  in  4  datapath status flags.
- `fs`  out  5  ALU function select.
- `addrR`, `addrA`, `addrB`  out  5 each  write, A and B register addresses.
- `k`  out  64  immediate.
- `s`  out  1  B operand select: 1 selects `k`.
- `sb`, `sd`  out  1 each  constant 1.
- `c0`  out  1  ALU carry-in.
- `w`  out  1  register-file write enable.
- `din`  out  64  register write data.
- `busy`  out  1  high in any state other than IDLE or HALT.
- `halted`  out  1  HALT instruction executed.
- `flags`  out  4  latched `status`.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
Instruction fields:
- [31:30] class: 00 = R (register-register), 01 = I (immediate), 10 = LOAD, 11 = HALT.
- [29:25] `fs`; [24:20] `addrR`; [19:15] `addrA`.
- R class: [14:10] `addrB`, [9] `c0`.
- I class: `k` = zero-extend([14:0]); `s` = 1; `c0` = 0; `addrB` = 0.
- R class: `s` = 0 and `k` = 0.

State machine:
- IDLE: `instr_ready` = 1. On a handshake, latch the fields into the output registers, then go to EXEC, or to HALT if class is 11.
- EXEC: control outputs are stable. Capture `f` into `din`, then go to WB. LOAD class goes to WAIT_LD instead and does not capture `f`.
- WAIT_LD: hold until `ld_valid`. Capture `ld_data` into `din`, then go to WB. `ld_valid` is ignored in every other state.
- WB: `w` = 1 for exactly one cycle, `retired` increments (wrapping modulo 2^CNT_W), then go to IDLE.
- HALT: `halted` = 1, `instr_ready` = 0. Only `rst` leaves this state.

Boundary rules:
- `addrR` == 31: `w` is suppressed in WB (zero register), but `retired` still increments.
- `fs`, `addr*`, `k`, `s` and `c0` hold their values from EXEC until the next accept; they do not return to 0 in IDLE.
- `rst` asserted mid-instruction aborts it: no `w` pulse and no `retired` increment.
- An instruction presented while busy is not consumed; its `instr_valid` must stay asserted.

## Timing
- Reset values: `sb` = `sd` = 1; `instr_ready` = 1. All other outputs are 0.
- Accept at cycle 0. Controls are valid from cycle 1 (EXEC). `w` = 1 in cycle 2 (WB). Next accept is possible in cycle 3.
- R and I instructions take 3 cycles each. LOAD takes 3 cycles plus the cycles spent waiting for `ld_valid`.
- `f` is sampled at the end of EXEC, so the datapath's combinational path must settle within one cycle.

## Configuration
- `DP_SEQ_FLAGS_EN` defined: `flags` loads `status` in WB of R and I instructions. LOAD and HALT leave `flags` unchanged.
- `DP_SEQ_FLAGS_EN` undefined: `flags` is tied to 0 and no flag register is built.

## Structure
- Package `dp_seq_pkg` holds the class encodings, the state enum (IDLE, EXEC, WAIT_LD, WB, HALT), the field bit positions and `ZERO_REG` = 31.
- Sub-module `dp_seq_decode` is combinational: instruction in, field and control values out.
- FSM, output registers and counter stay in the top module.

## Test plan
- ADD R0 = R23 + R20, with R23 = 5 and R20 = 18 preloaded via LOAD, `fs` = 01100 → `w` pulses in cycle 2 with `din` = 23; `retired` = 3 after the two LOADs and the ADD.
- I-type on R21 = 7 with imm 3, `fs` = 10000 → `s` = 1, `k` = 3 and `din` = `f` in WB; `addrB` = 0.
- LOAD with `ld_valid` delayed 5 cycles and `ld_data` = 64'hDEAD_BEEF → `busy` held for those 5 cycles; `w` pulses in the cycle after `ld_valid` with `din` = DEADBEEF.
- R type with `addrR` = 31 → no `w` pulse; `retired` still increments.
- HALT, then a valid instruction → `halted` = 1 and `instr_ready` stays 0; `rst` restores IDLE with all outputs at reset values.
- `rst` asserted in EXEC → no `w` pulse, `retired` unchanged at 0. With `DP_SEQ_FLAGS_EN` defined, `flags` = `status` captured in WB.
